mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of both sources and the output.
REQ-002 Parameter MAX_BURST, default 4, maximum consecutive transfers per grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_valid  input  1  source A offers a_data.
REQ-006 a_data  input  WIDTH  source A data (mux input a).
REQ-007 a_ready  output  1  A transfer occurs on a cycle with a_valid && a_ready.
REQ-008 b_valid  input  1  source B offers b_data.
REQ-009 b_data  input  WIDTH  source B data (mux input b).
REQ-010 b_ready  output  1  B transfer occurs on a cycle with b_valid && b_ready.
REQ-011 y_valid  output  1  registered output holds valid data.
REQ-012 y_data  output  WIDTH  registered output data.
REQ-013 y_ready  input  1  sink accepts; output handshake on y_valid && y_ready.
REQ-014 sel  output  1  mux select: 0 = A, 1 = B; equals 1 only in GRANT_B.
REQ-015 burst_cnt  output  4  transfers completed in the current grant.

Function
REQ-016 FSM states SHALL be IDLE, GRANT_A, GRANT_B; a_ready and b_ready SHALL be 0 in IDLE.
REQ-017 In IDLE: only a_valid -> GRANT_A; only b_valid -> GRANT_B; both -> the source not in last_grant; neither -> stay IDLE.
REQ-018 last_grant SHALL update to the granted source on every IDLE->GRANT_x transition.
REQ-019 load_ok SHALL equal (!y_valid || y_ready), combinationally.
REQ-020 In GRANT_A, a_ready SHALL equal load_ok and b_ready SHALL be 0; GRANT_B is symmetric.
REQ-021 On a transfer, y_data SHALL load the mux output (sel ? b_data : a_data), y_valid SHALL be 1 next cycle, and burst_cnt SHALL increment.
REQ-022 When load_ok is 1 and no transfer occurs, y_valid SHALL clear to 0 next cycle; when load_ok is 0, y_valid and y_data SHALL hold.
REQ-023 GRANT_x -> IDLE when a transfer occurs with burst_cnt == MAX_BURST-1, or when the granted source's valid is 0; burst_cnt SHALL clear to 0 on entry to IDLE.
REQ-024 GRANT_x SHALL otherwise hold, including while load_ok is 0 (backpressure never ends a grant).
REQ-025 Latency: request seen in IDLE at cycle N -> grant at N+1 -> first transfer at N+1 if load_ok -> y_valid at N+2.
REQ-026 Sustained throughput SHALL be one transfer per cycle within a grant; one idle re-arbitration cycle SHALL separate grants.
REQ-027 With MAX_BURST = 1, each grant SHALL carry exactly one transfer.
REQ-028 The non-granted source's data SHALL never reach y_data.

Reset
REQ-029 While rst = 1: state IDLE, last_grant = B, burst_cnt = 0, y_valid = 0, y_data = 0, sel = 0, a_ready = 0, b_ready = 0.
REQ-030 Reset asserted mid-burst SHALL discard the held output word and the grant immediately, without waiting for a clock edge.
REQ-031 After rst deasserts, A SHALL win the first simultaneous request.

Verification
REQ-032 Single source: A sends 0x11,0x22 with y_ready = 1 -> y_data 0x11, 0x22 on consecutive cycles starting 2 cycles after a_valid; sel = 0.
REQ-033 Contention: both valid continuously with MAX_BURST = 4, y_ready = 1 -> 4 A words, 1 bubble, 4 B words, 1 bubble, then A again; burst_cnt runs 0..3.
REQ-034 Backpressure: y_ready = 0 for 3 cycles mid-burst -> y_data holds, a_ready = 0, no words lost or duplicated, grant kept.
REQ-035 Early release: B drops b_valid after 2 words while A is waiting -> IDLE, then GRANT_A; burst_cnt returns to 0.
REQ-036 Reset mid-burst: rst pulse while y_valid = 1 holding 0x5A -> y_valid = 0 and y_data = 0 before the next clock edge; A wins the next tie.
REQ-037 Mutual exclusion: a_ready && b_ready never 1, and sel matches the source of every transfer; checked by assertion over random traffic.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Two-source round-robin arbiter feeding a one-word registered output stage.
// A grant lasts up to MAX_BURST transfers; backpressure stalls a grant but never ends it.
`timescale 1ns/1ps
module mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel,
    output logic [3:0]       burst_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t           r_state, w_state_nxt;
    logic             r_last_grant, w_last_nxt;   // 0 = A, 1 = B
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic [3:0]       r_burst_cnt;

    logic             w_load_ok, w_a_ready, w_b_ready, w_sel, w_xfer, w_gnt_valid;
    logic [WIDTH-1:0] w_mux;

    assign w_load_ok   = !r_y_valid || y_ready;
    assign w_a_ready   = (r_state == GRANT_A) && w_load_ok;
    assign w_b_ready   = (r_state == GRANT_B) && w_load_ok;
    assign w_sel       = (r_state == GRANT_B);
    assign w_xfer      = (a_valid && w_a_ready) || (b_valid && w_b_ready);
    assign w_mux       = w_sel ? b_data : a_data;
    assign w_gnt_valid = w_sel ? b_valid : a_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        case (r_state)
            IDLE: begin
                // On a tie, the source that did not hold the previous grant wins.
                if (a_valid && (!b_valid || r_last_grant)) begin
                    w_state_nxt = GRANT_A;
                    w_last_nxt  = 1'b0;
                end else if (b_valid) begin
                    w_state_nxt = GRANT_B;
                    w_last_nxt  = 1'b1;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!w_gnt_valid || (w_xfer && r_burst_cnt == LAST_CNT))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= 4'd0;
            r_y_valid    <= 1'b0;
            r_y_data     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            if (w_state_nxt == IDLE)
                r_burst_cnt <= 4'd0;
            else if (w_xfer)
                r_burst_cnt <= r_burst_cnt + 4'd1;
            // Output word is replaced on a transfer, drained when the sink takes it.
            if (w_xfer) begin
                r_y_valid <= 1'b1;
                r_y_data  <= w_mux;
            end else if (w_load_ok) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign a_ready   = w_a_ready;
    assign b_ready   = w_b_ready;
    assign sel       = w_sel;
    assign y_valid   = r_y_valid;
    assign y_data    = r_y_data;
    assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus random traffic
// against a transfer-queue scoreboard; a second instance runs with MAX_BURST = 1.
`timescale 1ns/1ps
module tb_mux2_arbiter;
    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0, rst = 1'b1;
    logic         a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic         a_ready, b_ready, y_valid, sel;
    logic [W-1:0] y_data;
    logic [3:0]   burst_cnt;
    logic         a_ready1, b_ready1, y_valid1, sel1;
    logic [W-1:0] y_data1;
    logic [3:0]   burst_cnt1;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(W), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel), .burst_cnt(burst_cnt)
    );

    mux2_arbiter #(.WIDTH(W), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .y_valid(y_valid1), .y_data(y_data1), .y_ready(y_ready),
        .sel(sel1), .burst_cnt(burst_cnt1)
    );

    a_mutex: assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready))
        else begin failures++; $display("FAIL assert_mutex a_ready=%b b_ready=%b", a_ready, b_ready); end
    a_sel_a: assert property (@(posedge clk) disable iff (rst) (a_valid && a_ready) |-> !sel)
        else begin failures++; $display("FAIL assert_sel_a sel=%b exp=0", sel); end
    a_sel_b: assert property (@(posedge clk) disable iff (rst) (b_valid && b_ready) |-> sel)
        else begin failures++; $display("FAIL assert_sel_b sel=%b exp=1", sel); end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 0; b_valid = 0; y_ready = 0; a_data = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1; b_valid = 1; y_ready = 1; a_data = 8'hFF; b_data = 8'hEE;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rst_y_valid got=%b exp=0", y_valid); end
        checks++; if (y_data !== 8'h00) begin failures++; $display("FAIL rst_y_data got=%h exp=00", y_data); end
        checks++; if (burst_cnt !== 4'd0) begin failures++; $display("FAIL rst_burst got=%0d exp=0", burst_cnt); end
        checks++; if ({sel, a_ready, b_ready} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {sel, a_ready, b_ready}); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        a_valid = 1; a_data = 8'h11; y_ready = 1;
        cyc();
        checks++; if (a_ready !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL single_grant a_ready=%b sel=%b exp=1,0", a_ready, sel); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL single_lat y_valid=%b exp=0", y_valid); end
        cyc();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h11) begin failures++; $display("FAIL single_w0 got=%b/%h exp=1/11", y_valid, y_data); end
        a_data = 8'h22;
        cyc();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h22) begin failures++; $display("FAIL single_w1 got=%b/%h exp=1/22", y_valid, y_data); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL single_sel got=%b exp=0", sel); end
        a_valid = 0;
        cyc();
        checks++; if (y_valid !== 1'b0 || burst_cnt !== 4'd0) begin failures++; $display("FAIL single_end y_valid=%b burst=%0d exp=0,0", y_valid, burst_cnt); end
    endtask

    task automatic test_contention();
        int i, j, i1, exp_cnt;
        logic         exp_v, exp_v1;
        logic [W-1:0] exp_d, exp_d1;
        do_reset();
        a_valid = 1; b_valid = 1; y_ready = 1;
        a_data = 8'hA0; b_data = 8'hB0;
        for (int n = 1; n <= 22; n++) begin
            cyc();
            j = n - 1;
            exp_cnt = (j % 5 == 4) ? 0 : j % 5;
            checks++; if (burst_cnt !== exp_cnt[3:0]) begin failures++; $display("FAIL cont_burst n=%0d got=%0d exp=%0d", n, burst_cnt, exp_cnt); end
            checks++; if (burst_cnt1 !== 4'd0) begin failures++; $display("FAIL cont_burst1 n=%0d got=%0d exp=0", n, burst_cnt1); end
            if (n >= 2) begin
                i  = (n - 2) % 10;
                i1 = (n - 2) % 4;
                exp_v  = !(i == 4 || i == 9);
                exp_d  = (i < 4 ? 8'hA0 : 8'hB0) | 8'((n - 1) & 15);
                exp_v1 = (i1 == 0 || i1 == 2);
                exp_d1 = (i1 == 0 ? 8'hA0 : 8'hB0) | 8'((n - 1) & 15);
                checks++; if (y_valid !== exp_v || (exp_v && y_data !== exp_d)) begin failures++; $display("FAIL cont_y n=%0d got=%b/%h exp=%b/%h", n, y_valid, y_data, exp_v, exp_d); end
                checks++; if (y_valid1 !== exp_v1 || (exp_v1 && y_data1 !== exp_d1)) begin failures++; $display("FAIL cont_y_mb1 n=%0d got=%b/%h exp=%b/%h", n, y_valid1, y_data1, exp_v1, exp_d1); end
            end
            a_data = 8'hA0 | 8'(n & 15);
            b_data = 8'hB0 | 8'(n & 15);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1; a_data = 8'h01; y_ready = 1;
        cyc();
        cyc();
        checks++; if (y_data !== 8'h01 || y_valid !== 1'b1) begin failures++; $display("FAIL bp_w1 got=%b/%h exp=1/01", y_valid, y_data); end
        a_data = 8'h02; y_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_ready k=%0d got=%b exp=0", k, a_ready); end
            cyc();
            checks++; if (y_valid !== 1'b1 || y_data !== 8'h01 || burst_cnt !== 4'd1) begin failures++; $display("FAIL bp_hold k=%0d got=%b/%h/%0d exp=1/01/1", k, y_valid, y_data, burst_cnt); end
        end
        y_ready = 1;
        #1;
        checks++; if (a_ready !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL bp_kept a_ready=%b sel=%b exp=1,0", a_ready, sel); end
        cyc();
        checks++; if (y_data !== 8'h02 || burst_cnt !== 4'd2) begin failures++; $display("FAIL bp_w2 got=%h/%0d exp=02/2", y_data, burst_cnt); end
        a_data = 8'h03;
        cyc();
        checks++; if (y_data !== 8'h03 || burst_cnt !== 4'd3) begin failures++; $display("FAIL bp_w3 got=%h/%0d exp=03/3", y_data, burst_cnt); end
    endtask

    task automatic test_early_release();
        do_reset();
        b_valid = 1; b_data = 8'hB1; y_ready = 1;
        cyc();
        checks++; if (sel !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL er_grant_b sel=%b b_ready=%b exp=1,1", sel, b_ready); end
        a_valid = 1; a_data = 8'hA1;
        cyc();
        checks++; if (y_data !== 8'hB1 || burst_cnt !== 4'd1) begin failures++; $display("FAIL er_b1 got=%h/%0d exp=B1/1", y_data, burst_cnt); end
        b_data = 8'hB2;
        cyc();
        checks++; if (y_data !== 8'hB2 || burst_cnt !== 4'd2) begin failures++; $display("FAIL er_b2 got=%h/%0d exp=B2/2", y_data, burst_cnt); end
        b_valid = 0;
        cyc();
        checks++; if ({sel, a_ready, b_ready} !== 3'b000 || burst_cnt !== 4'd0) begin failures++; $display("FAIL er_idle ctrl=%b burst=%0d exp=000/0", {sel, a_ready, b_ready}, burst_cnt); end
        cyc();
        checks++; if (a_ready !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL er_grant_a a_ready=%b sel=%b exp=1,0", a_ready, sel); end
        cyc();
        checks++; if (y_data !== 8'hA1 || y_valid !== 1'b1) begin failures++; $display("FAIL er_a1 got=%b/%h exp=1/A1", y_valid, y_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_valid = 1; a_data = 8'h5A; y_ready = 1;
        cyc();
        y_ready = 0;
        cyc();
        a_data = 8'h5B;
        cyc();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h5A || burst_cnt !== 4'd1) begin failures++; $display("FAIL rm_held got=%b/%h/%0d exp=1/5A/1", y_valid, y_data, burst_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (y_valid !== 1'b0 || y_data !== 8'h00) begin failures++; $display("FAIL rm_async got=%b/%h exp=0/00", y_valid, y_data); end
        checks++; if (burst_cnt !== 4'd0 || {sel, a_ready, b_ready} !== 3'b000) begin failures++; $display("FAIL rm_grant burst=%0d ctrl=%b exp=0/000", burst_cnt, {sel, a_ready, b_ready}); end
        #1 rst = 1'b0;
        a_valid = 1; b_valid = 1; y_ready = 1; a_data = 8'h66; b_data = 8'h77;
        cyc();
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || sel !== 1'b0) begin failures++; $display("FAIL rm_tie a_ready=%b b_ready=%b sel=%b exp=1,0,0", a_ready, b_ready, sel); end
        cyc();
        checks++; if (y_data !== 8'h66) begin failures++; $display("FAIL rm_first got=%h exp=66", y_data); end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic         hs_a, hs_b, out_hs;
        int           prev_cnt, exp_cnt;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            y_ready = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            #1;
            hs_a   = a_valid && a_ready;
            hs_b   = b_valid && b_ready;
            out_hs = y_valid && y_ready;
            prev_cnt = int'(burst_cnt);
            checks++; if ((a_ready || b_ready) && !(!y_valid || y_ready)) begin failures++; $display("FAIL rnd_load_ok c=%0d ready=%b%b y_valid=%b y_ready=%b", c, a_ready, b_ready, y_valid, y_ready); end
            checks++; if (burst_cnt >= 4'(MB) || (a_ready1 && b_ready1) || (a_ready1 && sel1) || (b_ready1 && !sel1)) begin failures++; $display("FAIL rnd_rules c=%0d burst=%0d r1=%b%b sel1=%b", c, burst_cnt, a_ready1, b_ready1, sel1); end
            if (out_hs && q.size() > 0) void'(q.pop_front());
            if (hs_a) q.push_back(a_data);
            if (hs_b) q.push_back(b_data);
            cyc();
            checks++; if (y_valid !== (q.size() != 0) || (q.size() != 0 && y_data !== q[0])) begin failures++; $display("FAIL rnd_y c=%0d got=%b/%h exp=%b/%h", c, y_valid, y_data, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00); end
            if (hs_a || hs_b) begin
                exp_cnt = (prev_cnt + 1 == MB) ? 0 : prev_cnt + 1;
                checks++; if (burst_cnt !== exp_cnt[3:0]) begin failures++; $display("FAIL rnd_burst c=%0d got=%0d exp=%0d", c, burst_cnt, exp_cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
